axis_burst_framer: RTL and testbench
====================================

# axis_burst_framer

Downstream companion of the block-RAM AXI4-Stream FIFO. It watches the FIFO's read-side occupancy and releases data only in whole bursts of a configured length, appending `m_axis_tlast` on the final beat. This gives DMA writers and packet senders fixed-size frames. It sits between the FIFO's master port and any frame-oriented consumer, and reports a frame counter for software.

## Interface
- `AXIS_TDATA_WIDTH`, 32: data width, both sides.
- `CNTR_WIDTH`, 16: width of the burst-length and beat counters; must be ≤ 16 to match the FIFO count port.
- `aclk` input 1: the single clock.
- `aresetn` input 1: asynchronous, active-low reset (already decided). Asserts asynchronously, releases synchronously to `aclk`.
- `cfg_data` input `CNTR_WIDTH`: burst length in beats. 0 means disabled.
- `fifo_count` input 16: FIFO read-side occupancy (FIFO `read_count`).
- `sts_data` output 32: number of completed frames.
- `s_axis_tdata` input `AXIS_TDATA_WIDTH`; `s_axis_tvalid` input 1; `s_axis_tready` output 1.
- `m_axis_tdata` output `AXIS_TDATA_WIDTH`; `m_axis_tvalid` output 1; `m_axis_tready` input 1; `m_axis_tlast` output 1.

## Operation
- States: IDLE and BURST (one register `int_busy_reg`). Additional registers:
  - `int_len_reg`: latched length.
  - `int_cntr_reg`: beat index, counts from 0.
  - `int_frame_reg`: completed-frame count.
- IDLE → BURST when `cfg_data != 0` and `fifo_count >= cfg_data` (unsigned; `cfg_data` zero-extended to 16 bits).
  - On that transition: `int_len_reg <= cfg_data` and `int_cntr_reg <= 0`.
- In BURST, data passes straight through with no register stage:
  - `m_axis_tdata = s_axis_tdata`.
  - `m_axis_tvalid = s_axis_tvalid & busy`.
  - `s_axis_tready = m_axis_tready & busy`.
- In IDLE, `s_axis_tready = 0` and `m_axis_tvalid = 0`.
- A beat is a cycle with `s_axis_tvalid & m_axis_tready & busy`. Each beat increments `int_cntr_reg`.
- `m_axis_tlast = busy & (int_cntr_reg == int_len_reg - 1)`.
- Beat with tlast high → IDLE, and `int_frame_reg` increments. It is 32-bit and wraps from 0xFFFFFFFF to 0.
- `cfg_data` changes mid-burst do not affect the current burst; the new value applies to the next burst.
- If `fifo_count` drops below the length mid-burst (not expected with a FIFO), the block stalls on `s_axis_tvalid` and never truncates the frame.
- `sts_data = int_frame_reg`.
- Reset (any time, including mid-burst) returns to IDLE with all counters at 0. A partial frame is abandoned without tlast.

## Timing
- Reset values: `s_axis_tready = 0`, `m_axis_tvalid = 0`, `m_axis_tlast = 0`, `sts_data = 0`. `m_axis_tdata` follows `s_axis_tdata`.
- Zero-cycle data latency in BURST (combinational pass-through).
- Burst start: the threshold condition is sampled at cycle N, and the first beat can transfer in cycle N+1.
- Bursts are always separated by at least one IDLE cycle. This lets `fifo_count` reflect the completed burst before the next threshold check.
- Length 1: tlast is high on the first beat.
- Maximum length is 2^`CNTR_WIDTH` − 1.

## Configuration
- `AXIS_BURST_FRAMER_TIMEOUT_EN` defined: adds input `cfg_timeout` (32 bits) and a 32-bit idle-cycle counter.
  - The counter runs while in IDLE with `fifo_count != 0` and `cfg_timeout != 0`.
  - It clears on entering BURST or when `fifo_count == 0`.
  - When it reaches `cfg_timeout`, the block enters BURST with `int_len_reg <= fifo_count` (truncated to `CNTR_WIDTH` bits; if the count exceeds the maximum, use the maximum). This flushes a short frame ending in tlast, and `int_frame_reg` increments for it.
- Macro undefined: no `cfg_timeout` port and no timer. Only full-length bursts are ever emitted.

## Structure
- Shared package: state encoding localparams (IDLE=0, BURST=1) and the 32-bit status width constant.
- Single flat module. The optional timeout timer is small enough to stay inline, so no sub-module is needed.

## Test plan
- Length 8, FIFO preloaded with 20 words, `m_axis_tready = 1` → two frames of 8 beats with tlast on beats 8 and 16. 4 words remain. `sts_data = 2`. Exactly one IDLE cycle between the two frames.
- Length 4, `m_axis_tready` toggling 1,0,1,0 → each beat held stable while ready is 0. tlast on the 4th accepted beat only. `sts_data = 1`.
- Length 5, FIFO count 4 → `s_axis_tready` stays 0 indefinitely (no timeout). Push one more word → 5-beat frame.
- `cfg_data` changed from 4 to 6 during the 2nd beat → current frame is 4 beats, next frame is 6.
- `aresetn` low on the 3rd beat of an 8-beat burst → all outputs 0 within the reset. After release, a fresh 8-beat frame is produced and `sts_data` counts from 0.
- With `AXIS_BURST_FRAMER_TIMEOUT_EN`: length 16, `cfg_timeout = 100`, 3 words pushed → after 100 IDLE cycles, a 3-beat frame with tlast on beat 3, and `sts_data = 1`.

Source files
------------

// File: rtl/axis_burst_framer_pkg.sv
// -----------------------------------------------------------------------------
// axis_burst_framer_pkg
// Shared definitions for the AXI4-Stream burst framer:
//   - framer state encoding (IDLE = 0, BURST = 1)
//   - width of the software-visible frame counter
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package axis_burst_framer_pkg;

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_BURST = 1'b1;

    localparam int STS_WIDTH = 32;

    typedef enum logic {
        IDLE  = STATE_IDLE,
        BURST = STATE_BURST
    } framer_state_t;

endpackage : axis_burst_framer_pkg

// File: rtl/axis_burst_framer.sv
// -----------------------------------------------------------------------------
// axis_burst_framer
// Sits on the master side of a block-RAM AXI4-Stream FIFO and releases data
// only in whole bursts of cfg_data beats, marking the last beat with tlast.
// Data passes through combinationally while a burst is open.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   cfg_data             burst length in beats (0 = disabled)
//   fifo_count           FIFO read-side occupancy
//   cfg_timeout          idle timeout in cycles (0 = off), only with
//                        AXIS_BURST_FRAMER_TIMEOUT_EN
//   sts_data             number of completed frames (wraps)
//   s_axis_*             slave stream from the FIFO
//   m_axis_*             framed master stream
//
// Build option:
//   AXIS_BURST_FRAMER_TIMEOUT_EN  flush a short frame once data has sat in the
//                                 FIFO for cfg_timeout idle cycles.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module axis_burst_framer
    import axis_burst_framer_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [CNTR_WIDTH-1:0]       cfg_data,
    input  logic [15:0]                 fifo_count,
`ifdef AXIS_BURST_FRAMER_TIMEOUT_EN
    input  logic [31:0]                 cfg_timeout,
`endif
    output logic [STS_WIDTH-1:0]        sts_data,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast
);

    framer_state_t          int_busy_reg;
    framer_state_t          w_state_next;
    logic [CNTR_WIDTH-1:0]  int_len_reg;
    logic [CNTR_WIDTH-1:0]  int_cntr_reg;
    logic [STS_WIDTH-1:0]   int_frame_reg;

    logic                   w_busy;
    logic                   w_beat;
    logic                   w_last;
    logic                   w_threshold;
    logic                   w_start;
    logic [CNTR_WIDTH-1:0]  w_start_len;
    logic                   w_timeout;
    logic [CNTR_WIDTH-1:0]  w_flush_len;

    assign w_busy = (int_busy_reg == BURST);
    assign w_beat = s_axis_tvalid & m_axis_tready & w_busy;
    assign w_last = w_busy & (int_cntr_reg == int_len_reg - CNTR_WIDTH'(1));

    // Length is zero-extended to the 16-bit FIFO count before comparing.
    assign w_threshold = (cfg_data != '0) && (fifo_count >= 16'(cfg_data));

    // Combinational pass-through; handshakes are gated by the burst state.
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = s_axis_tvalid & w_busy;
    assign s_axis_tready = m_axis_tready & w_busy;
    assign m_axis_tlast  = w_last;
    assign sts_data      = int_frame_reg;

`ifdef AXIS_BURST_FRAMER_TIMEOUT_EN
    localparam logic [CNTR_WIDTH-1:0] LEN_MAX    = {CNTR_WIDTH{1'b1}};
    localparam logic [15:0]           LEN_MAX_16 = 16'(LEN_MAX);

    logic [31:0] int_timer_reg;

    // The timer only counts while something is waiting in the FIFO; a
    // saturated count of fifo_count forms the flush length.
    assign w_timeout   = (int_busy_reg == IDLE) && (fifo_count != '0) &&
                         (cfg_timeout != '0) && (int_timer_reg >= cfg_timeout);
    assign w_flush_len = (fifo_count > LEN_MAX_16) ? LEN_MAX
                                                   : fifo_count[CNTR_WIDTH-1:0];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            int_timer_reg <= '0;
        end else if (w_start || w_busy || fifo_count == '0 || cfg_timeout == '0) begin
            int_timer_reg <= '0;
        end else if (int_timer_reg != 32'hFFFF_FFFF) begin
            int_timer_reg <= int_timer_reg + 32'd1;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign w_flush_len = '0;
`endif

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_next = int_busy_reg;
        w_start      = 1'b0;
        w_start_len  = cfg_data;
        case (int_busy_reg)
            IDLE: begin
                // A full-length burst takes priority over a timeout flush.
                if (w_threshold) begin
                    w_state_next = BURST;
                    w_start      = 1'b1;
                    w_start_len  = cfg_data;
                end else if (w_timeout) begin
                    w_state_next = BURST;
                    w_start      = 1'b1;
                    w_start_len  = w_flush_len;
                end
            end
            BURST: begin
                // Leaving after the tlast beat guarantees one IDLE cycle
                // between bursts so fifo_count can catch up.
                if (w_beat && w_last) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            int_busy_reg  <= IDLE;
            int_len_reg   <= '0;
            int_cntr_reg  <= '0;
            int_frame_reg <= '0;
        end else begin
            int_busy_reg <= w_state_next;
            // Length is latched once per burst, so cfg_data changes only
            // take effect on the next burst.
            if (w_start) begin
                int_len_reg  <= w_start_len;
                int_cntr_reg <= '0;
            end else if (w_beat) begin
                int_cntr_reg <= int_cntr_reg + CNTR_WIDTH'(1);
            end
            if (w_beat && w_last) begin
                int_frame_reg <= int_frame_reg + 32'd1;
            end
        end
    end

endmodule : axis_burst_framer

// File: tb/tb_axis_burst_framer.sv
// -----------------------------------------------------------------------------
// tb_axis_burst_framer
// Scoreboard bench for axis_burst_framer. A small FIFO model feeds the slave
// port and reports its occupancy on fifo_count; every word pushed that should
// leave as part of a frame gets its expected {tlast, tdata} queued, and a
// monitor compares each accepted master beat against the queue head.
// Define AXIS_BURST_FRAMER_TIMEOUT_EN to also exercise the timeout flush.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_axis_burst_framer;

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] cfg_data = '0;
    logic [15:0] fifo_count = '0;
    logic [31:0] sts_data;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
`ifdef AXIS_BURST_FRAMER_TIMEOUT_EN
    logic [31:0] cfg_timeout = '0;
`endif

    always #5 aclk = ~aclk;

    axis_burst_framer #(
        .AXIS_TDATA_WIDTH (32),
        .CNTR_WIDTH       (16)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_data      (cfg_data),
        .fifo_count    (fifo_count),
`ifdef AXIS_BURST_FRAMER_TIMEOUT_EN
        .cfg_timeout   (cfg_timeout),
`endif
        .sts_data      (sts_data),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    logic [31:0] src_q[$];
    logic [32:0] exp_q[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   beats    = 0;
    int   ready_cycles = 0;
    int   last_tlast_cyc = 0;
    int   gap      = -1;
    logic after_last = 1'b0;
    logic fire     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO model: pops the word accepted at the previous edge, then presents
    // the new head and occupancy shortly after the edge.
    always @(posedge aclk) begin
        logic [31:0] dropped;
        #1;
        if (fire && src_q.size() != 0) begin
            dropped = src_q.pop_front();
        end
        s_axis_tvalid = (src_q.size() != 0);
        s_axis_tdata  = (src_q.size() != 0) ? src_q[0] : 32'h0;
        fifo_count    = 16'(src_q.size());
    end

    // Monitor: sampled mid-cycle, where all handshake signals are settled.
    always @(negedge aclk) begin
        logic [32:0] exp_beat;
        cyc++;
        fire = s_axis_tvalid && s_axis_tready;
        if (s_axis_tready) ready_cycles++;
        if (m_axis_tvalid && m_axis_tready) begin
            beats++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got data 0x%0h last %0b expected no beat", m_axis_tdata, m_axis_tlast);
            end else begin
                exp_beat = exp_q.pop_front();
                check("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_beat));
            end
            if (after_last) gap = cyc - last_tlast_cyc;
            after_last = m_axis_tlast;
            if (m_axis_tlast) last_tlast_cyc = cyc;
        end
    end

    task automatic push_src(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) src_q.push_back(base + 32'(i));
    endtask

    task automatic push_exp(input logic [31:0] base, input int n, input int len);
        for (int i = 0; i < n; i++) exp_q.push_back({((i + 1) % len) == 0, base + 32'(i)});
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge aclk);
            k++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic wait_beats(input int target, input int budget);
        int k = 0;
        while (beats < target && k < budget) begin
            @(posedge aclk);
            k++;
        end
        check("beat_wait", 64'(beats >= target), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
        check({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        check({tag, "_m_tlast"},  64'(m_axis_tlast),  64'd0);
        check({tag, "_sts"},      64'(sts_data),      64'd0);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        src_q.delete();
        exp_q.delete();
        cfg_data      = '0;
        m_axis_tready = 1'b1;
`ifdef AXIS_BURST_FRAMER_TIMEOUT_EN
        cfg_timeout   = '0;
`endif
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int r0;
        int b0;

        // Reset state
        #2;
        check_idle_outputs("reset");
        do_reset();

        // Length 8, 20 words: two frames, 4 words left, one idle cycle between
        cfg_data = 16'd8;
        push_src(32'hA000_0000, 20);
        push_exp(32'hA000_0000, 16, 8);
        wait_drain(200);
        repeat (3) @(posedge aclk);
        #1;
        check("t1_sts", 64'(sts_data), 64'd2);
        check("t1_gap", 64'(gap), 64'd2);
        check("t1_left", 64'(src_q.size()), 64'd4);

        // Length 4 with tready toggling
        do_reset();
        push_src(32'hB000_0000, 4);
        push_exp(32'hB000_0000, 4, 4);
        repeat (3) @(posedge aclk);
        #1;
        cfg_data = 16'd4;
        for (int i = 0; i < 16; i++) begin
            @(posedge aclk);
            #1;
            m_axis_tready = ~m_axis_tready;
        end
        m_axis_tready = 1'b1;
        wait_drain(100);
        check("t2_sts", 64'(sts_data), 64'd1);

        // Length 5 with only 4 words: no release until a fifth arrives
        do_reset();
        cfg_data = 16'd5;
        push_src(32'hC000_0000, 4);
        push_exp(32'hC000_0000, 5, 5);
        r0 = ready_cycles;
        repeat (30) @(posedge aclk);
        #1;
        check("t3_ready_cycles", 64'(ready_cycles - r0), 64'd0);
        check("t3_sts_before", 64'(sts_data), 64'd0);
        push_src(32'hC000_0004, 1);
        wait_drain(100);
        check("t3_sts", 64'(sts_data), 64'd1);

        // Length change 4 -> 6 during the second beat
        do_reset();
        cfg_data = 16'd4;
        push_src(32'hD000_0000, 10);
        push_exp(32'hD000_0000, 4, 4);
        push_exp(32'hD000_0004, 6, 6);
        b0 = beats;
        wait_beats(b0 + 1, 100);
        #1;
        cfg_data = 16'd6;
        wait_drain(100);
        check("t4_sts", 64'(sts_data), 64'd2);

        // Reset during the third beat of an 8-beat burst
        do_reset();
        cfg_data = 16'd8;
        push_src(32'hE000_0000, 8);
        push_exp(32'hE000_0000, 2, 8);
        b0 = beats;
        wait_beats(b0 + 2, 100);
        #1;
        aresetn = 1'b0;
        #1;
        check_idle_outputs("t5_in_reset");
        check("t5_partial", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge aclk);
        src_q.delete();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        push_src(32'hF000_0000, 8);
        push_exp(32'hF000_0000, 8, 8);
        wait_drain(100);
        check("t5_sts", 64'(sts_data), 64'd1);

`ifdef AXIS_BURST_FRAMER_TIMEOUT_EN
        // Timeout flush of a short frame
        do_reset();
        cfg_data    = 16'd16;
        cfg_timeout = 32'd100;
        push_src(32'h1234_0000, 3);
        push_exp(32'h1234_0000, 3, 3);
        repeat (50) @(posedge aclk);
        #1;
        check("to_early", 64'(exp_q.size()), 64'd3);
        wait_drain(300);
        check("to_sts", 64'(sts_data), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_axis_burst_framer
